cache_port_arbiter8: RTL
========================

# cache_port_arbiter8

Round-robin arbiter sharing one cache access port among eight requesters. It grants one requester at a time and drives the 3-bit select of the 8-to-1 request-field muxes (tag/index/way fields) in front of the phased cache. The grant is held until the cache signals completion, with a watchdog that force-releases a stuck grant. Grants can be issued back-to-back with no idle bubble between them.

## Interface
- MAX_HOLD, 15: maximum number of cycles a grant may be held without `done`. Legal range is 1..255.
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req  in  8  request lines; bit i is requester i. Level-sensitive.
- done  in  1  cache reports that the current granted access is complete. Single-cycle pulse.
- sel  out  3  registered index of the granted requester; drives the mux `sel`.
- gnt  out  8  registered one-hot grant; 8'h00 when idle.
- busy  out  1  registered; 1 while any grant is active.
- timeout  out  1  registered one-cycle pulse when the watchdog forces a release.

## Operation
- Internal state:
  - FSM with states IDLE and GRANT.
  - 3-bit priority pointer `ptr`.
  - 8-bit hold counter `cnt`.
- Winner selection: the first set bit of `req` scanning ptr, ptr+1, …, ptr+7, with indices taken mod 8.
- IDLE:
  - If `req` is nonzero, register the winner into `sel`/`gnt`, set `busy`=1, set `cnt`=1, and go to GRANT.
  - If `req` is zero, stay in IDLE.
  - `done` is ignored in IDLE.
- GRANT, on the cycle with done=1:
  - Release the grant and set ptr = sel+1 (mod 8, so 7 wraps to 0).
  - Arbitrate the same cycle using the updated ptr; the just-served requester therefore has lowest priority.
  - If any `req` bit is set, load the new winner, keep `busy`=1, set `cnt`=1, and stay in GRANT.
  - Otherwise set gnt=0, busy=0, and go to IDLE.
- GRANT, with done=0 and cnt < MAX_HOLD: hold `sel`/`gnt` and increment `cnt`.
- GRANT, with done=0 and cnt == MAX_HOLD: forced release, handled exactly like done=1, and `timeout` is 1 in the next cycle.
- Deasserting `req[i]` while granted does not release the grant; only `done` or the watchdog releases it.
- `sel` holds its last granted value while idle, so the mux output stays stable.
- Invariant: `gnt` is either 8'h00 or one-hot, and gnt == (8'h01 << sel) whenever busy=1.

## Timing
- Reset values: sel=0, gnt=8'h00, busy=0, timeout=0, ptr=0, cnt=0, state IDLE. Reset takes effect at the first rising edge with rst_n=0.
- Reset mid-grant: outputs clear at that edge and `done` is ignored. After rst_n returns to 1, arbitration restarts from ptr=0.
- Grant latency: `req` sampled at edge N produces `gnt`/`sel`/`busy` valid after edge N (one cycle).
- Release on `done` sampled at edge N:
  - The new grant, or gnt=0, is visible after edge N.
  - There are zero bubble cycles between consecutive grants.
- Watchdog: with no `done`, `gnt` is high for exactly MAX_HOLD cycles. `timeout` is high for the one cycle following the last held cycle, coincident with the next grant or with gnt=0.
- `done` and the watchdog limit coinciding: treat it as a normal `done`; timeout stays 0.
- `done` with req=8'h00: busy drops after that edge and `ptr` still advances.

## Test plan
- Reset: hold rst_n=0 with req=8'hFF and done=1 for 3 cycles -> sel=0, gnt=8'h00, busy=0, timeout=0 throughout.
- Single requester: req=8'h20 -> one cycle later gnt=8'h20, sel=5, busy=1. Then pulse done -> next cycle gnt=8'h00, busy=0.
- Fairness: req=8'hFF held, with done pulsed in every grant's first cycle -> sel sequence 0,1,2,3,4,5,6,7,0 on consecutive cycles, with busy never dropping.
- Wrap and priority: finish a grant to 6 (ptr=7), then req=8'h41 -> requester 0 is granted next, then 6 after its done.
- Watchdog (MAX_HOLD=15): req=8'h03 with no done -> gnt=8'h01 for exactly 15 cycles, then timeout=1 for one cycle with gnt=8'h02. `done` coinciding with cycle 15 -> timeout stays 0.
- Robustness:
  - done pulsed while idle -> no state change.
  - req[3] dropped mid-grant -> gnt=8'h08 held until done.
  - rst_n=0 mid-grant -> all outputs clear at that edge; the next grant with req=8'hFF is requester 0.

Source files
------------

// File: rtl/cache_port_arbiter8.sv
// cache_port_arbiter8
//   Round-robin arbiter that shares one cache access port among eight
//   requesters. The grant stays with one requester until the cache pulses
//   done or until a watchdog force-releases it after MAX_HOLD cycles.
//   On release, arbitration happens in the same cycle, so consecutive
//   grants follow each other with no idle cycle in between.
//
// Parameters
//   MAX_HOLD  cycles a grant may be held without done (legal 1..255)
//
// Ports
//   clk      in   system clock, rising edge
//   rst_n    in   synchronous active-low reset
//   req      in   [7:0] level-sensitive request lines, bit i = requester i
//   done     in   single-cycle completion pulse for the current grant
//   sel      out  [2:0] registered index of the granted requester (mux select)
//   gnt      out  [7:0] registered one-hot grant, 8'h00 when idle
//   busy     out  registered, high while a grant is active
//   timeout  out  registered one-cycle pulse after a watchdog release
module cache_port_arbiter8 #(
    parameter int unsigned MAX_HOLD = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       done,
    output logic [2:0] sel,
    output logic [7:0] gnt,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);

    state_t     state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] sel_q, sel_d;
    logic [7:0] gnt_q, gnt_d;
    logic       timeout_q, timeout_d;

    logic [2:0] arb_ptr;
    logic [2:0] scan_idx;
    logic [2:0] win_idx;
    logic       win_vld;
    logic       release_now;

    // While granted, a release always moves the pointer to sel+1, so the
    // same-cycle arbitration can use that value directly instead of ptr_q.
    always_comb begin
        arb_ptr  = (state_q == GRANT) ? sel_q + 3'd1 : ptr_q;
        win_idx  = '0;
        win_vld  = 1'b0;
        scan_idx = '0;
        for (int unsigned k = 0; k < 8; k++) begin
            scan_idx = arb_ptr + 3'(k);
            if (!win_vld && req[scan_idx]) begin
                win_idx = scan_idx;
                win_vld = 1'b1;
            end
        end
    end

    assign release_now = done || (cnt_q == HOLD_LIM);

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        sel_d     = sel_q;
        gnt_d     = gnt_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    sel_d   = win_idx;
                    gnt_d   = 8'd1 << win_idx;
                    cnt_d   = 8'd1;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (release_now) begin
                    // done wins over a coinciding watchdog limit
                    timeout_d = !done;
                    ptr_d     = arb_ptr;
                    if (win_vld) begin
                        sel_d = win_idx;
                        gnt_d = 8'd1 << win_idx;
                        cnt_d = 8'd1;
                    end else begin
                        gnt_d   = '0;
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            cnt_q     <= '0;
            sel_q     <= '0;
            gnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            sel_q     <= sel_d;
            gnt_q     <= gnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign sel     = sel_q;
    assign gnt     = gnt_q;
    assign busy    = (state_q == GRANT);
    assign timeout = timeout_q;

endmodule
